clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning divisor and counter width in bits.
REQ-002 SHALL have parameter DEFAULT_DIV, default 6, meaning the divisor in effect after reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  meaning run enable.
REQ-006 SHALL have port div_in  input  WIDTH  meaning the requested divisor D.
REQ-007 SHALL have port div_load  input  1  meaning a one-cycle strobe that captures div_in.
REQ-008 SHALL have port clk_out  output  1  meaning the divided clock, registered.
REQ-009 SHALL have port tick  output  1  meaning a one-cycle pulse in the first cycle of each clk_out period, registered.
REQ-010 SHALL have port div_cur  output  WIDTH  meaning the divisor in effect.
REQ-011 SHALL have port load_busy  output  1  meaning a captured divisor is pending.
REQ-012 SHALL have port load_ack  output  1  meaning a one-cycle pulse when the pending divisor takes effect.
REQ-013 SHALL have port div_err  output  1  meaning a one-cycle pulse when a load is rejected.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and RUN.
REQ-015 IDLE to RUN SHALL occur on the first cycle with en=1; on that edge cnt<=0, clk_out<=1 and tick<=1.
REQ-016 RUN to IDLE SHALL occur on any cycle with en=0; on the next edge cnt<=0, clk_out<=0 and tick<=0.
REQ-017 In RUN, cnt SHALL advance 0..D-1 and then wrap to 0, giving a period of exactly D clk cycles.
REQ-018 clk_out SHALL be 1 while cnt < H, where H=(D+1)>>1, and 0 otherwise, so high time is ceil(D/2) and low time is floor(D/2).
REQ-019 tick SHALL be 1 only while cnt==0 in RUN, so exactly one tick occurs per period.
REQ-020 Counter arithmetic SHALL be WIDTH bits and SHALL never overflow, since D-1 <= 2^WIDTH-2.
REQ-021 A div_load with div_in>=2 SHALL capture div_in into the pending register and set load_busy on the next cycle.
REQ-022 A div_load with div_in<2 SHALL be ignored and SHALL pulse div_err for one cycle; pending state is unchanged.
REQ-023 A div_load while load_busy=1 SHALL overwrite the pending value (last wins), with a single load_ack at apply time.
REQ-024 In RUN, the pending divisor SHALL be applied only at the wrap edge (cnt==D-1 to 0), so the new period uses the new D; load_ack SHALL coincide with that period's tick; load_busy SHALL clear.
REQ-025 A div_load in the same cycle as a wrap SHALL NOT apply at that wrap; it SHALL apply at the following wrap.
REQ-026 In IDLE, the pending divisor SHALL be applied on the next edge, with a load_ack pulse.
REQ-027 No clk_out period SHALL be truncated or extended by a divisor change (glitch-free).

Reset
REQ-028 On reset=1, the state SHALL be IDLE, cnt=0, clk_out=0, tick=0, div_cur=DEFAULT_DIV, load_busy=0, load_ack=0 and div_err=0; a pending load SHALL be discarded.
REQ-029 Reset SHALL override en, div_load and sync in the same cycle; after reset deasserts, operation SHALL follow REQ-015.

Configuration
REQ-030 With CLKDIV_SYNC_EN defined, the block SHALL add input sync (1 bit); sync=1 in RUN SHALL restart the period on the next edge (cnt<=0, clk_out<=1, tick<=1), apply any pending divisor with load_ack, and take priority over a normal wrap.
REQ-031 Without CLKDIV_SYNC_EN, the sync port and its logic SHALL be absent, and behaviour SHALL be as in REQ-014..REQ-027.

Structure
REQ-032 Package clk_div_pkg SHALL hold the FSM state enum (IDLE, RUN) and the constant MIN_DIV=2.
REQ-033 The pending-divisor capture, validation and busy flag logic SHALL be a sub-module named clk_div_pend.

Verification
REQ-034 Reset, then en=1 with DEFAULT_DIV=6 -> clk_out pattern 111000 repeats, and tick occurs every 6 cycles starting the first en cycle.
REQ-035 Load 5 in IDLE, then en=1 -> load_ack the next cycle, div_cur=5, and clk_out pattern 11100 repeats.
REQ-036 Running with D=6, load 4 at cnt=2 -> the current period completes all 6 cycles; the next period is 1100 with load_ack on its tick; load_busy=1 for exactly 3 cycles (cnt=3,4,5).
REQ-037 Load 1 -> div_err pulses once, load_busy stays 0, and div_cur is unchanged.
REQ-038 Running, drop en at cnt=3 -> clk_out=0 and tick=0 the next cycle; en=1 again -> the period restarts at cnt=0 with a tick.
REQ-039 Assert reset at cnt=4 with load 9 pending -> all outputs return to reset values, div_cur=6, and the pending 9 is never applied.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   state_e : run-state encoding (IDLE, RUN), fixed values for legacy compatibility
//   MIN_DIV : smallest divisor the block accepts
package clk_div_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_pend.sv
// Pending-divisor holder: validates and captures load requests and tracks the busy flag.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   div_load, div_in  : load strobe and requested divisor
//   apply             : the top consumes the pending value on this edge
//   pend_div          : captured divisor awaiting application
//   load_busy         : a captured divisor is pending
//   div_err           : one-cycle pulse after a rejected (< MIN_DIV) load
module clk_div_pend
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  input  logic             apply,
  output logic [WIDTH-1:0] pend_div,
  output logic             load_busy,
  output logic             div_err
);

  logic [WIDTH-1:0] pend_q;
  logic             busy_q;
  logic             err_q;
  logic             load_ok;

  assign load_ok = div_load && (div_in >= WIDTH'(MIN_DIV));

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= div_load && !load_ok;
      // A fresh capture wins over consumption so a load on the apply edge stays pending.
      if (load_ok) begin
        pend_q <= div_in;
        busy_q <= 1'b1;
      end else if (apply) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign pend_div  = pend_q;
  assign load_busy = busy_q;
  assign div_err   = err_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free divisor updates.
// clk_out has period D clk cycles, high for ceil(D/2), low for floor(D/2); tick marks the
// first cycle of each period. New divisors are applied only at a period boundary (or at once
// while idle). Optional feature: define CLKDIV_SYNC_EN to add the sync restart input.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   en                : run enable
//   sync              : (CLKDIV_SYNC_EN only) restart the current period
//   div_in, div_load  : requested divisor and its capture strobe
//   clk_out, tick     : divided clock and period-start pulse, registered
//   div_cur           : divisor in effect
//   load_busy         : a divisor is pending
//   load_ack          : pulse when the pending divisor takes effect
//   div_err           : pulse when a load is rejected
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur,
  output logic             load_busy,
  output logic             load_ack,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             ack_q;
  logic             apply;
  logic             restart;
  logic             sync_hit;
  logic [WIDTH-1:0] pend_div;

  // ceil(d/2) without the overflow that d+1 would risk at d = 2^WIDTH-1
  function automatic logic [WIDTH-1:0] high_len(input logic [WIDTH-1:0] d);
    return (d >> 1) + {{(WIDTH-1){1'b0}}, d[0]};
  endfunction

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  assign restart = (cnt_q == div_q - WIDTH'(1)) || sync_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    apply   = 1'b0;
    case (state_q)
      IDLE: begin
        apply = load_busy;
        if (en) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (restart) begin
          cnt_d = '0;
          apply = load_busy;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    div_d     = apply ? pend_div : div_q;
    // Outputs are derived from the next count and divisor so they line up with cnt_q.
    clk_out_d = (state_d == RUN) && (cnt_d < high_len(div_d));
    tick_d    = (state_d == RUN) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DefDiv;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      ack_q     <= apply;
    end
  end

  clk_div_pend #(
    .WIDTH(WIDTH)
  ) u_pend (
    .clk      (clk),
    .reset    (reset),
    .div_load (div_load),
    .div_in   (div_in),
    .apply    (apply),
    .pend_div (pend_div),
    .load_busy(load_busy),
    .div_err  (div_err)
  );

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign div_cur  = div_q;
  assign load_ack = ack_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed table, hand-written corner sequences and
// randomized stimulus compared cycle by cycle against a behavioural period model.
module tb_clk_div_prog;

  localparam int DefDiv = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       sync;
  logic [7:0] div_in;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_cur;
  logic       load_busy;
  logic       load_ack;
  logic       div_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_div_prog #(
    .WIDTH      (8),
    .DEFAULT_DIV(DefDiv)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
`ifdef CLKDIV_SYNC_EN
    .sync     (sync),
`endif
    .div_in   (div_in),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_cur  (div_cur),
    .load_busy(load_busy),
    .load_ack (load_ack),
    .div_err  (div_err)
  );

  // Behavioural model: position within the current period, divisor, pending request.
  bit m_run;
  int m_pos;
  int m_div;
  bit m_busy;
  int m_pend;
  bit m_ack;
  bit m_err;
  bit m_ck;
  bit m_tk;

  task automatic model_edge();
    bit take;
    take = 1'b0;
    if (reset) begin
      m_run = 0; m_pos = 0; m_div = DefDiv; m_busy = 0; m_pend = 0; m_ack = 0; m_err = 0;
    end else begin
      if (!m_run) begin
        take = m_busy;
        if (en) begin
          m_run = 1; m_pos = 0;
        end
      end else if (!en) begin
        m_run = 0; m_pos = 0;
      end else if (m_pos == m_div - 1 || sync) begin
        m_pos = 0; take = m_busy;
      end else begin
        m_pos = m_pos + 1;
      end
      m_ack = take;
      if (take) m_div = m_pend;
      m_err = div_load && (int'(div_in) < 2);
      if (div_load && int'(div_in) >= 2) begin
        m_pend = int'(div_in); m_busy = 1;
      end else if (take) begin
        m_busy = 0;
      end
    end
    m_ck = m_run && (m_pos < (m_div + 1) / 2);
    m_tk = m_run && (m_pos == 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: model follows the edge, DUT sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_clk_out", clk_out, m_ck);
    chk("m_tick", tick, m_tk);
    chk("m_div_cur", div_cur, m_div);
    chk("m_load_busy", load_busy, m_busy);
    chk("m_load_ack", load_ack, m_ack);
    chk("m_div_err", div_err, m_err);
  endtask

  task automatic drive(input bit r, input bit e, input bit l, input int d);
    reset = r; en = e; div_load = l; div_in = 8'(d);
  endtask

  typedef struct {
    bit rst; bit en; bit ld; int din;
    bit ck; bit tk; int dc; bit bz; bit ak; bit er;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit rst, input bit e, input bit ld, input int din, input bit ck,
                     input bit tk, input int dc, input bit bz, input bit ak, input bit er);
    vec_t v;
    v.rst = rst; v.en = e; v.ld = ld; v.din = din;
    v.ck = ck; v.tk = tk; v.dc = dc; v.bz = bz; v.ak = ak; v.er = er;
    tbl.push_back(v);
  endtask

  initial begin
    sync = 1'b0;
    drive(1, 0, 0, 0);

    //  rst en ld din | clk tick div busy ack err
    add(1, 0, 0, 0,  0, 0, 6, 0, 0, 0);
    add(1, 1, 1, 5,  0, 0, 6, 0, 0, 0);  // reset beats en and load
    add(0, 0, 0, 0,  0, 0, 6, 0, 0, 0);
    add(0, 1, 0, 0,  1, 1, 6, 0, 0, 0);  // first en cycle: tick
    add(0, 1, 0, 0,  1, 0, 6, 0, 0, 0);
    add(0, 1, 0, 0,  1, 0, 6, 0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 6, 0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 6, 0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 6, 0, 0, 0);
    add(0, 1, 0, 0,  1, 1, 6, 0, 0, 0);  // 111000 repeats
    add(0, 1, 1, 1,  1, 0, 6, 0, 0, 1);  // load 1 rejected
    add(0, 1, 0, 0,  1, 0, 6, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 6, 0, 0, 0);  // back to idle
    add(0, 0, 1, 5,  0, 0, 6, 1, 0, 0);  // load 5 while idle
    add(0, 1, 0, 0,  1, 1, 5, 0, 1, 0);  // applied with ack
    add(0, 1, 0, 0,  1, 0, 5, 0, 0, 0);
    add(0, 1, 0, 0,  1, 0, 5, 0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 5, 0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 5, 0, 0, 0);
    add(0, 1, 0, 0,  1, 1, 5, 0, 0, 0);  // 11100 repeats
    add(1, 1, 1, 9,  0, 0, 6, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 6, 0, 0, 0);  // pending load discarded

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].ld, tbl[i].din);
      step();
      chk($sformatf("t%0d_clk_out", i), clk_out, tbl[i].ck);
      chk($sformatf("t%0d_tick", i), tick, tbl[i].tk);
      chk($sformatf("t%0d_div_cur", i), div_cur, tbl[i].dc);
      chk($sformatf("t%0d_busy", i), load_busy, tbl[i].bz);
      chk($sformatf("t%0d_ack", i), load_ack, tbl[i].ak);
      chk($sformatf("t%0d_err", i), div_err, tbl[i].er);
    end

    // Mid-period load of 4 at cnt=2 with D=6.
    drive(1, 0, 0, 0); step();
    drive(0, 1, 0, 0); step(); step(); step();
    chk("ld4_pre_busy", load_busy, 0);
    drive(0, 1, 1, 4); step(); drive(0, 1, 0, 0);
    chk("ld4_c3_busy", load_busy, 1);
    chk("ld4_c3_div", div_cur, 6);
    step(); chk("ld4_c4_busy", load_busy, 1);
    step(); chk("ld4_c5_busy", load_busy, 1); chk("ld4_c5_clk", clk_out, 0);
    step();
    chk("ld4_wrap_tick", tick, 1);
    chk("ld4_wrap_ack", load_ack, 1);
    chk("ld4_wrap_busy", load_busy, 0);
    chk("ld4_wrap_div", div_cur, 4);
    chk("ld4_wrap_clk", clk_out, 1);
    step(); chk("ld4_p1_clk", clk_out, 1); chk("ld4_p1_ack", load_ack, 0);
    step(); chk("ld4_p2_clk", clk_out, 0);
    step(); chk("ld4_p3_clk", clk_out, 0);
    step(); chk("ld4_next_tick", tick, 1);

    // Drop en at cnt=3 with D=6, then restart.
    drive(1, 0, 0, 0); step();
    drive(0, 1, 0, 0); step(); step(); step(); step();
    drive(0, 0, 0, 0); step();
    chk("en_off_clk", clk_out, 0);
    chk("en_off_tick", tick, 0);
    drive(0, 1, 0, 0); step();
    chk("en_on_tick", tick, 1);
    chk("en_on_clk", clk_out, 1);

    // Reset at cnt=4 with 9 pending: the 9 must never appear.
    drive(1, 0, 0, 0); step();
    drive(0, 1, 0, 0); step(); step();
    drive(0, 1, 1, 9); step(); drive(0, 1, 0, 0);
    chk("rst9_busy", load_busy, 1);
    step(); step();
    drive(1, 1, 0, 0); step();
    chk("rst9_clk", clk_out, 0);
    chk("rst9_tick", tick, 0);
    chk("rst9_div", div_cur, 6);
    chk("rst9_busy_clr", load_busy, 0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rst9_div_keep", div_cur, 6);
      chk("rst9_no_ack", load_ack, 0);
    end

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 15) != 0,
            $urandom_range(0, 5) == 0,
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 9)));
`ifdef CLKDIV_SYNC_EN
      sync = ($urandom_range(0, 31) == 0);
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
